// File: rtl/palette_lut.sv
// Programmable colour-lookup unit: palette index -> faded RGB in exactly two cycles.
// Runtime-writable palette with a transparency index, frame-synchronous colour cycling and global fade.
module palette_lut #(
   parameter int ENTRIES    = 18,
   parameter int IDX_W      = 5,
   parameter int CH_W       = 8,
   parameter int TRANSP_IDX = 0,
   parameter int CYC_BASE   = 12,
   parameter int CYC_LEN    = 3,
   parameter int CYC_PERIOD = 16,
   parameter int FADE_W     = 3
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              pix_valid,
   input  logic [IDX_W-1:0]  pix_idx,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [3*CH_W-1:0] wr_rgb,
   input  logic [FADE_W-1:0] fade_lvl,
   input  logic              cyc_en,
   input  logic              frame_tick,
   output logic              out_valid,
   output logic [CH_W-1:0]   out_r,
   output logic [CH_W-1:0]   out_g,
   output logic [CH_W-1:0]   out_b,
   output logic              out_transp
);

   localparam int FC_W  = (CYC_PERIOD > 1) ? $clog2(CYC_PERIOD) : 1;
   localparam int OFF_W = (CYC_LEN > 1) ? $clog2(CYC_LEN) : 1;
   localparam int RGB_W = 3 * CH_W;

   localparam logic [IDX_W:0]   NENT   = (IDX_W+1)'(ENTRIES);
   localparam logic [IDX_W:0]   CB     = (IDX_W+1)'(CYC_BASE);
   localparam logic [IDX_W:0]   CL     = (IDX_W+1)'(CYC_LEN);
   localparam logic [IDX_W-1:0] TIDX   = IDX_W'(TRANSP_IDX);
   localparam logic [FC_W-1:0]  FC_MAX = FC_W'(CYC_PERIOD - 1);
   localparam logic [OFF_W-1:0] OFF_MAX = OFF_W'(CYC_LEN - 1);

   // Handshake: pix_valid qualifies pix_idx in the cycle it is high; out_valid follows exactly
   // two cycles later. There is no ready: the pipeline accepts one pixel every cycle.

   function automatic logic [RGB_W-1:0] def_rgb(input int i);
      logic [7:0]      r, g, b;
      logic [CH_W-1:0] rr, gg, bb;
      case (i)
         0:  {r, g, b} = {8'd0,   8'd0,   8'd1};
         1:  {r, g, b} = {8'd99,  8'd99,  8'd99};
         2:  {r, g, b} = {8'd107, 8'd8,   8'd0};
         3:  {r, g, b} = {8'd156, 8'd74,  8'd0};
         4:  {r, g, b} = {8'd173, 8'd173, 8'd173};
         5:  {r, g, b} = {8'd255, 8'd255, 8'd255};
         6:  {r, g, b} = {8'd90,  8'd0,   8'd123};
         7:  {r, g, b} = {8'd181, 8'd49,  8'd33};
         8:  {r, g, b} = {8'd0,   8'd66,  8'd74};
         9:  {r, g, b} = {8'd231, 8'd231, 8'd148};
         10: {r, g, b} = {8'd107, 8'd107, 8'd0};
         11: {r, g, b} = {8'd231, 8'd156, 8'd33};
         12: {r, g, b} = {8'd181, 8'd247, 8'd206};
         13: {r, g, b} = {8'd0,   8'd82,  8'd0};
         14: {r, g, b} = {8'd0,   8'd140, 8'd49};
         15: {r, g, b} = {8'd255, 8'd255, 8'd254};
         16: {r, g, b} = {8'd89,  8'd13,  8'd121};
         default: {r, g, b} = 24'd0;
      endcase
      rr = CH_W'(r) << (CH_W - 8);
      gg = CH_W'(g) << (CH_W - 8);
      bb = CH_W'(b) << (CH_W - 8);
      return {rr, gg, bb};
   endfunction

   // Product is one bit wider than CH_W+FADE_W so the multiplier 2^FADE_W fits.
   function automatic logic [CH_W-1:0] fade_ch(input logic [CH_W-1:0] c, input logic [FADE_W-1:0] lvl);
      logic [FADE_W:0]      mult;
      logic [CH_W+FADE_W:0] prod;
      mult = (FADE_W+1)'(2**FADE_W) - {1'b0, lvl};
      prod = (CH_W+FADE_W+1)'(c) * (CH_W+FADE_W+1)'(mult);
      return prod[FADE_W +: CH_W];
   endfunction

   logic [RGB_W-1:0]  pal [ENTRIES];
   logic [FC_W-1:0]   frame_cnt;
   logic [OFF_W-1:0]  offset;

   logic              s1_valid;
   logic              s1_transp;
   logic [FADE_W-1:0] s1_fade;
   logic [RGB_W-1:0]  s1_rgb;

   logic [RGB_W-1:0]  out_rgb;

   logic              in_win;
   logic [IDX_W:0]    rel;
   logic [IDX_W:0]    eff_w;
   logic [IDX_W-1:0]  eff;
   logic [RGB_W-1:0]  rd_rgb;
   logic [RGB_W-1:0]  faded;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < ENTRIES; i++)
            pal[i] <= (i < 18) ? def_rgb(i) : '0;
      end else if (wr_en && ({1'b0, wr_idx} < NENT)) begin
         pal[wr_idx] <= wr_rgb;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset || !cyc_en) begin
         frame_cnt <= '0;
         offset    <= '0;
      end else if (frame_tick) begin
         if (frame_cnt == FC_MAX) begin
            frame_cnt <= '0;
            offset    <= (offset == OFF_MAX) ? '0 : offset + 1'b1;
         end else begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   // Rotation applies to the requested index only; the sum stays below 2*CYC_LEN, so one subtract wraps it.
   always_comb begin
      in_win = ({1'b0, pix_idx} >= CB) && ({1'b0, pix_idx} < CB + CL);
      rel    = {1'b0, pix_idx} - CB + (IDX_W+1)'(offset);
      if (rel >= CL)
         rel = rel - CL;
      eff_w  = in_win ? (CB + rel) : {1'b0, pix_idx};
      eff    = eff_w[IDX_W-1:0];
      rd_rgb = ({1'b0, pix_idx} < NENT) ? pal[eff] : '0;
   end

   always_comb begin
      faded = {fade_ch(s1_rgb[2*CH_W +: CH_W], s1_fade),
               fade_ch(s1_rgb[CH_W   +: CH_W], s1_fade),
               fade_ch(s1_rgb[0      +: CH_W], s1_fade)};
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_valid   <= 1'b0;
         s1_transp  <= 1'b0;
         s1_fade    <= '0;
         s1_rgb     <= '0;
         out_valid  <= 1'b0;
         out_transp <= 1'b0;
         out_rgb    <= '0;
      end else begin
         s1_valid  <= pix_valid;
         out_valid <= s1_valid;
         if (pix_valid) begin
            s1_transp <= (pix_idx == TIDX);
            s1_fade   <= fade_lvl;
            s1_rgb    <= rd_rgb;
         end
         if (s1_valid) begin
            out_transp <= s1_transp;
            out_rgb    <= s1_transp ? '0 : faded;
         end
      end
   end

   assign out_r = out_rgb[2*CH_W +: CH_W];
   assign out_g = out_rgb[CH_W   +: CH_W];
   assign out_b = out_rgb[0      +: CH_W];

endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut: lookups, writes, fade, colour cycling and reset behaviour.
module tb_palette_lut;

   logic        clk = 1'b0;
   logic        reset;
   logic        pix_valid;
   logic [4:0]  pix_idx;
   logic        wr_en;
   logic [4:0]  wr_idx;
   logic [23:0] wr_rgb;
   logic [2:0]  fade_lvl;
   logic        cyc_en;
   logic        frame_tick;
   logic        out_valid;
   logic [7:0]  out_r, out_g, out_b;
   logic        out_transp;

   int total = 0;
   int bad   = 0;

   logic [24:0] exp_q[$];
   logic [1:0]  vpipe = 2'b00;

   palette_lut #(.CYC_PERIOD(2)) dut (
      .Clk(clk), .Reset(reset), .pix_valid(pix_valid), .pix_idx(pix_idx),
      .wr_en(wr_en), .wr_idx(wr_idx), .wr_rgb(wr_rgb), .fade_lvl(fade_lvl),
      .cyc_en(cyc_en), .frame_tick(frame_tick), .out_valid(out_valid),
      .out_r(out_r), .out_g(out_g), .out_b(out_b), .out_transp(out_transp)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [24:0] px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                      input logic t);
      return {t, r, g, b};
   endfunction

   // expected-latency model and scoreboard
   always @(posedge clk) begin
      if (reset) begin
         vpipe <= 2'b00;
         exp_q.delete();
      end else begin
         vpipe <= {vpipe[0], pix_valid};
      end
   end

   always @(negedge clk) begin
      logic [24:0] e;
      check("out_valid", {31'd0, out_valid}, {31'd0, vpipe[1]});
      if (out_valid && vpipe[1]) begin
         check("q_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pixel", {7'd0, out_transp, out_r, out_g, out_b}, {7'd0, e});
         end
      end
   end

   // drivers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input logic [4:0] idx, input logic [2:0] fade, input logic [24:0] exp);
      pix_valid = 1'b1;
      pix_idx   = idx;
      fade_lvl  = fade;
      exp_q.push_back(exp);
      step();
      pix_valid = 1'b0;
      fade_lvl  = 3'd0;
   endtask

   task automatic idle(input int n);
      pix_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic tick_frame();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   initial begin
      reset = 1'b1; pix_valid = 1'b0; pix_idx = '0; wr_en = 1'b0; wr_idx = '0;
      wr_rgb = '0; fade_lvl = '0; cyc_en = 1'b0; frame_tick = 1'b0;
      idle(3);
      check("rst_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);
      check("rst_transp", {31'd0, out_transp}, 32'd0);
      reset = 1'b0;
      idle(1);

      // basic lookups
      pix(5'd5, 3'd0, px(255, 255, 255, 0));
      pix(5'd17, 3'd0, px(0, 0, 0, 0));
      idle(3);

      // transparency, out of range, back-to-back
      pix(5'd0, 3'd0, px(0, 0, 0, 1));
      pix(5'd20, 3'd0, px(0, 0, 0, 0));
      pix(5'd1, 3'd0, px(99, 99, 99, 0));
      pix(5'd2, 3'd0, px(107, 8, 0, 0));
      pix(5'd3, 3'd0, px(156, 74, 0, 0));
      idle(3);
      check("hold_rgb", {8'd0, out_r, out_g, out_b}, {8'd0, 8'd156, 8'd74, 8'd0});

      // write port: read-before-write, then new value
      wr_en = 1'b1; wr_idx = 5'd3; wr_rgb = {8'd10, 8'd20, 8'd30};
      pix(5'd3, 3'd0, px(156, 74, 0, 0));
      wr_en = 1'b0;
      pix(5'd3, 3'd0, px(10, 20, 30, 0));
      wr_en = 1'b1; wr_idx = 5'd25; wr_rgb = 24'hffffff;
      pix(5'd3, 3'd0, px(10, 20, 30, 0));
      wr_en = 1'b0;
      pix(5'd5, 3'd0, px(255, 255, 255, 0));
      pix(5'd17, 3'd0, px(0, 0, 0, 0));
      pix(5'd25, 3'd0, px(0, 0, 0, 0));
      idle(3);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      idle(2);
      pix(5'd3, 3'd0, px(156, 74, 0, 0));
      idle(3);

      // fade
      pix(5'd5, 3'd4, px(127, 127, 127, 0));
      pix(5'd9, 3'd7, px(28, 28, 18, 0));
      pix(5'd5, 3'd0, px(255, 255, 255, 0));
      pix(5'd0, 3'd4, px(0, 0, 0, 1));
      idle(3);

      // colour cycling, period 2 frames
      cyc_en = 1'b1;
      idle(1);
      tick_frame();
      tick_frame();
      pix(5'd12, 3'd0, px(0, 82, 0, 0));
      pix(5'd14, 3'd0, px(181, 247, 206, 0));
      pix(5'd13, 3'd0, px(0, 140, 49, 0));
      pix(5'd11, 3'd0, px(231, 156, 33, 0));
      tick_frame();
      frame_tick = 1'b1;
      pix(5'd12, 3'd0, px(0, 82, 0, 0));
      frame_tick = 1'b0;
      pix(5'd12, 3'd0, px(0, 140, 49, 0));
      tick_frame();
      tick_frame();
      pix(5'd12, 3'd0, px(181, 247, 206, 0));
      idle(3);

      // physical write inside the window, then drop cyc_en
      tick_frame();
      tick_frame();
      wr_en = 1'b1; wr_idx = 5'd13; wr_rgb = {8'd1, 8'd2, 8'd3};
      idle(1);
      wr_en = 1'b0;
      pix(5'd12, 3'd0, px(1, 2, 3, 0));
      cyc_en = 1'b0;
      idle(1);
      pix(5'd12, 3'd0, px(181, 247, 206, 0));
      tick_frame();
      tick_frame();
      pix(5'd12, 3'd0, px(181, 247, 206, 0));
      pix(5'd13, 3'd0, px(1, 2, 3, 0));
      idle(3);

      // reset mid-stream
      pix(5'd1, 3'd0, px(99, 99, 99, 0));
      pix(5'd2, 3'd0, px(107, 8, 0, 0));
      reset = 1'b1;
      pix(5'd3, 3'd0, px(156, 74, 0, 0));
      reset = 1'b0;
      check("rst_mid_valid0", {31'd0, out_valid}, 32'd0);
      check("rst_mid_rgb0", {7'd0, out_transp, out_r, out_g, out_b}, 32'd0);
      pix(5'd4, 3'd0, px(173, 173, 173, 0));
      check("rst_mid_valid1", {31'd0, out_valid}, 32'd0);
      check("rst_mid_rgb1", {7'd0, out_transp, out_r, out_g, out_b}, 32'd0);
      pix(5'd5, 3'd0, px(255, 255, 255, 0));
      idle(4);

      check("q_drained", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
